// File: rtl/regfile_wb_scoreboard_pkg.sv
// Purpose: shared RV32I datapath constants and helpers for the register file slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

  // Default data width of one architectural register.
  localparam int RV_XLEN = 32;

  // Default number of architectural registers.
  localparam int RV_NREG = 32;

  // Address of the hardwired-zero register.
  localparam int RV_ZERO_ADDR = 0;

  // Ceiling log2 for flows without $clog2; returns 0 for n <= 1.
  function automatic int rv_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_wb_scoreboard_onehot_decoder.sv
// Purpose: one-hot decode of an address with enable; out-of-range addresses decode to all zeros.
// Latency: combinational.
// Backpressure: none.
// Ports: en (decode enable), addr (AW-bit index), out (NOUT-bit one-hot or zero).
module onehot_decoder #(
  parameter int NOUT = 32,
  parameter int AW   = 5
) (
  input  logic            en,
  input  logic [AW-1:0]   addr,
  output logic [NOUT-1:0] out
);

  always_comb begin
    out = '0;
    // AW can cover more codes than NOUT when NOUT is not a power of two.
    if (en && (32'(addr) < NOUT)) begin
      out[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Purpose: RV32I register file with write-through bypass, optional hardwired x0 and a pending-write scoreboard.
// Latency: writes and scoreboard updates land 1 cycle after the edge; reads/bypass/busy_x are combinational.
// Backpressure: none; every write and issue is accepted on the edge it is presented.
// Ports: clk/rst (sync active-high); wr_en/wr_addr/wr_data writeback port; iss_en/iss_addr issue port;
//        rd_addr_a/b -> rd_data_a/b, busy_a/b read ports; wen_vec decoded write strobe; busy_vec/pending_cnt scoreboard.
module regfile_wb_scoreboard
  import rv32i_pkg::*;
#(
  parameter int XLEN     = RV_XLEN,
  parameter int NREG     = RV_NREG,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_b,
  output logic            busy_a,
  output logic            busy_b,
  output logic [NREG-1:0] wen_vec,
  output logic [NREG-1:0] busy_vec,
  output logic [CW-1:0]   pending_cnt
);

  // Registers that may be written, issued to, or read as stored data.
  localparam logic [NREG-1:0] VALID_MASK =
    (ZERO_REG != 0) ? ~(NREG'(1) << RV_ZERO_ADDR) : '1;

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_cnt;

  logic [NREG-1:0] w_wen_raw;
  logic [NREG-1:0] w_set_raw;
  logic [NREG-1:0] w_wen_vec;
  logic [NREG-1:0] w_set_vec;
  logic [NREG-1:0] w_busy_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  // Writes are suppressed during reset so the strobe never claims a write that is discarded.
  onehot_decoder #(.NOUT(NREG), .AW(AW)) u_wen_dec (
    .en   (wr_en & ~rst),
    .addr (wr_addr),
    .out  (w_wen_raw)
  );

  onehot_decoder #(.NOUT(NREG), .AW(AW)) u_iss_dec (
    .en   (iss_en),
    .addr (iss_addr),
    .out  (w_set_raw)
  );

  assign w_wen_vec = w_wen_raw & VALID_MASK;
  assign w_set_vec = w_set_raw & VALID_MASK;

  // Set beats clear: a fresh producer supersedes the one retiring this cycle.
  assign w_busy_nxt = (r_busy & ~w_wen_vec) | w_set_vec;

  always_comb begin
    w_cnt_nxt = '0;
    for (int k = 0; k < NREG; k++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= '0;
      end
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (w_wen_vec[k]) begin
          r_regs[k] <= wr_data;
        end
      end
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Read ports scan the valid registers so invalid addresses fall through to zero / not busy.
  // A source written this cycle sees the bypassed data and is reported as not busy.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    busy_a    = 1'b0;
    busy_b    = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (VALID_MASK[k] && (rd_addr_a == AW'(k))) begin
        rd_data_a = w_wen_vec[k] ? wr_data : r_regs[k];
        busy_a    = r_busy[k] & ~w_wen_vec[k];
      end
      if (VALID_MASK[k] && (rd_addr_b == AW'(k))) begin
        rd_data_b = w_wen_vec[k] ? wr_data : r_regs[k];
        busy_b    = r_busy[k] & ~w_wen_vec[k];
      end
    end
  end

  assign wen_vec     = w_wen_vec;
  assign busy_vec    = r_busy;
  assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
module tb_regfile_wb_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 24;
  localparam int AW   = 5;
  localparam int CW   = 5;

  logic            clk;
  logic            rst;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [AW-1:0]   rd_addr_a;
  logic [XLEN-1:0] rd_data_a;
  logic [AW-1:0]   rd_addr_b;
  logic [XLEN-1:0] rd_data_b;
  logic            busy_a;
  logic            busy_b;
  logic [NREG-1:0] wen_vec;
  logic [NREG-1:0] busy_vec;
  logic [CW-1:0]   pending_cnt;

  int vectors;
  int miscompares;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  regfile_wb_scoreboard #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .wen_vec     (wen_vec),
    .busy_vec    (busy_vec),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the expected value at the moment the stimulus implying it is driven.
  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with what the DUT produced.
  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] z_n(input logic [NREG-1:0] v);
    return {8'b0, v};
  endfunction

  function automatic logic [31:0] z_c(input logic [CW-1:0] v);
    return {27'b0, v};
  endfunction

  function automatic logic [31:0] z_b(input logic v);
    return {31'b0, v};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr_a = '0; rd_addr_b = '0;

    // 1. reset and basic write
    tick();
    rst = 1'b0;
    #1;
    expect_val("rst_busy_vec", 32'h0);     check(z_n(busy_vec));
    expect_val("rst_pending", 32'h0);      check(z_c(pending_cnt));
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(31 - i);
      #1;
      expect_val("rst_rd_a", 32'h0);       check(rd_data_a);
      expect_val("rst_rd_b", 32'h0);       check(rd_data_b);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    expect_val("wr5_wen_vec", 32'h20);
    #1;                                    check(z_n(wen_vec));
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd5;
    expect_val("wr5_rd_a", 32'hDEADBEEF);
    #1;                                    check(rd_data_a);

    // 2. hardwired zero
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr_a = 5'd0;
    expect_val("x0_wen_vec", 32'h0);
    expect_val("x0_rd_bypass", 32'h0);
    #1;                                    check(z_n(wen_vec)); check(rd_data_a);
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd0;
    expect_val("x0_rd_after", 32'h0);
    #1;                                    check(rd_data_a);
    tick();
    iss_en = 1'b0;
    expect_val("x0_iss_busy_vec", 32'h0);
    expect_val("x0_iss_pending", 32'h0);
    expect_val("x0_busy_a", 32'h0);
    #1;                                    check(z_n(busy_vec)); check(z_c(pending_cnt)); check(z_b(busy_a));

    // 3. bypass with busy source
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    iss_en = 1'b0; rd_addr_b = 5'd7;
    expect_val("byp_busy_b_before", 32'h1);
    #1;                                    check(z_b(busy_b));
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    expect_val("byp_rd_b", 32'hA5A5A5A5);
    expect_val("byp_busy_b", 32'h0);
    #1;                                    check(rd_data_b); check(z_b(busy_b));
    tick();
    wr_en = 1'b0;
    expect_val("byp_busy_vec_after", 32'h0);
    expect_val("byp_rd_b_stored", 32'hA5A5A5A5);
    #1;                                    check(z_n(busy_vec)); check(rd_data_b);

    // 4. scoreboard sequence
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd9;
    tick();
    iss_en = 1'b0; rd_addr_a = 5'd3;
    expect_val("sb_busy_vec_2", 32'h208);
    expect_val("sb_pending_2", 32'd2);
    expect_val("sb_busy_a3", 32'h1);
    #1;                                    check(z_n(busy_vec)); check(z_c(pending_cnt)); check(z_b(busy_a));
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    wr_en = 1'b0;
    expect_val("sb_busy_vec_wr3", 32'h200);
    expect_val("sb_pending_wr3", 32'd1);
    #1;                                    check(z_n(busy_vec)); check(z_c(pending_cnt));
    iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    iss_en = 1'b0; wr_en = 1'b0; rd_addr_a = 5'd9;
    expect_val("sb_set_wins_vec", 32'h200);
    expect_val("sb_set_wins_cnt", 32'd1);
    expect_val("sb_busy_a9", 32'h1);
    expect_val("sb_rd_a9", 32'h99);
    #1;                                    check(z_n(busy_vec)); check(z_c(pending_cnt)); check(z_b(busy_a)); check(rd_data_a);

    // 5. out of range
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'hFFFFFFFF; rd_addr_a = 5'd30;
    expect_val("oor_wen_vec", 32'h0);
    expect_val("oor_rd_a", 32'h0);
    expect_val("oor_busy_a", 32'h0);
    #1;                                    check(z_n(wen_vec)); check(rd_data_a); check(z_b(busy_a));
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd5; iss_en = 1'b1; iss_addr = 5'd30;
    expect_val("oor_reg5_kept", 32'hDEADBEEF);
    #1;                                    check(rd_data_a);
    tick();
    iss_en = 1'b0;
    expect_val("oor_iss_vec", 32'h200);
    expect_val("oor_iss_cnt", 32'd1);
    #1;                                    check(z_n(busy_vec)); check(z_c(pending_cnt));

    // 6. reset mid-operation
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0;
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd1;
    tick();
    iss_addr = 5'd2;
    tick();
    iss_addr = 5'd4;
    tick();
    iss_en = 1'b0;
    expect_val("mid_busy_vec", 32'h16);
    expect_val("mid_pending", 32'd3);
    #1;                                    check(z_n(busy_vec)); check(z_c(pending_cnt));
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'd5;
    expect_val("mid_rst_wen_vec", 32'h0);
    #1;                                    check(z_n(wen_vec));
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_addr_a = 5'd1; rd_addr_b = 5'd5;
    expect_val("mid_rst_busy_vec", 32'h0);
    expect_val("mid_rst_pending", 32'h0);
    expect_val("mid_rst_reg1", 32'h0);
    expect_val("mid_rst_reg5", 32'h0);
    #1;                                    check(z_n(busy_vec)); check(z_c(pending_cnt)); check(rd_data_a); check(rd_data_b);

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
